// File: rtl/icap_stream_feeder.sv
// Feeds 64-bit AXI-Stream bitstream beats to ICAPE3 as 32-bit words.
// Handles AVAIL throttling, tkeep checks, PRDONE/PRERROR and status.
module icap_stream_feeder #(
  parameter bit          BIT_SWAP       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic        AxiBusClock,
  input  logic        xAxiBusReset_n,
  input  logic [63:0] xS_AXIS_tdata,
  input  logic [7:0]  xS_AXIS_tkeep,
  input  logic        xS_AXIS_tlast,
  input  logic        xS_AXIS_tvalid,
  output logic        xS_AXIS_tready,
  input  logic        xIcapAvail,
  input  logic        xIcapPrDone,
  input  logic        xIcapPrError,
  output logic        xIcapCsib,
  output logic        xIcapRdwrb,
  output logic [31:0] xIcapI,
  input  logic        xEnable,
  input  logic        xAbort,
  output logic        xBusy,
  output logic        xDone,
  output logic [1:0]  xErrCode,
  output logic [31:0] xWordCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] w0;
  logic [31:0] w1;
  logic [1:0]  cnt;
  logic        tlast_seen;
  logic        discard_done;
  logic [31:0] tmo;

  logic        hs;
  logic        keep_full;
  logic        keep_ok;
  logic        pend;
  logic        issue;
  logic        tmo_hit;
  logic [1:0]  err_nxt;
  logic        disc_nxt;
  logic        flush;
  logic        arm;
  logic        tmo_clr;
  logic        tmo_inc;

  function automatic logic [31:0] swap_bits(input logic [31:0] d);
    logic [31:0] o;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) begin
        o[8*k+i] = d[8*k+7-i];
      end
    end
    return o;
  endfunction

  assign hs        = xS_AXIS_tvalid & xS_AXIS_tready;
  assign keep_full = (xS_AXIS_tkeep == 8'hFF);
  assign keep_ok   = keep_full |
                     ((xS_AXIS_tkeep == 8'h0F) & xS_AXIS_tlast);
  assign pend      = (cnt != 2'd0);
  assign tmo_hit   = (tmo == TMO_LAST);
  assign issue     = (state == S_STREAM) & pend & xIcapAvail &
                     ~xIcapPrError & ~xAbort;

  assign xIcapRdwrb = 1'b0;
  assign xBusy      = (state == S_STREAM) | (state == S_DRAIN);
  assign xDone      = (state == S_DONE);

  // Ready never depends on tvalid, so no loop through hs.
  always_comb begin
    xS_AXIS_tready = 1'b0;
    unique case (state)
      S_STREAM: xS_AXIS_tready = ~tlast_seen &
                  ((cnt == 2'd0) | ((cnt == 2'd1) & issue));
      S_ERROR:  xS_AXIS_tready = ~discard_done;
      default:  xS_AXIS_tready = 1'b0;
    endcase
    if (xAbort) xS_AXIS_tready = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = xErrCode;
    disc_nxt  = discard_done;
    flush     = 1'b0;
    arm       = 1'b0;
    tmo_clr   = 1'b0;
    tmo_inc   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (xEnable) begin
          arm       = 1'b1;
          err_nxt   = 2'd0;
          state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (xIcapPrError) begin
          state_nxt = S_ERROR;
          err_nxt   = 2'd2;
          flush     = 1'b1;
          disc_nxt  = tlast_seen | (hs & xS_AXIS_tlast);
        end else if (hs && !keep_ok) begin
          state_nxt = S_ERROR;
          err_nxt   = 2'd1;
          flush     = 1'b1;
          disc_nxt  = tlast_seen | xS_AXIS_tlast;
        end else if (pend && !xIcapAvail) begin
          if (tmo_hit) begin
            state_nxt = S_ERROR;
            err_nxt   = 2'd3;
            flush     = 1'b1;
            disc_nxt  = tlast_seen;
          end else begin
            tmo_inc = 1'b1;
          end
        end else if (issue) begin
          tmo_clr = 1'b1;
          if (cnt == 2'd1 && tlast_seen) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (xIcapPrError) begin
          state_nxt = S_ERROR;
          err_nxt   = 2'd2;
          disc_nxt  = 1'b1;
        end else if (xIcapPrDone) begin
          state_nxt = S_DONE;
        end else if (tmo_hit) begin
          state_nxt = S_ERROR;
          err_nxt   = 2'd3;
          disc_nxt  = 1'b1;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      S_DONE: begin
        if (!xEnable) state_nxt = S_IDLE;
      end
      S_ERROR: begin
        if (hs && xS_AXIS_tlast) disc_nxt = 1'b1;
        if (!xEnable && discard_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (xAbort) begin
      state_nxt = S_IDLE;
      err_nxt   = xErrCode;
      flush     = 1'b1;
      arm       = 1'b0;
    end
  end

  always_ff @(posedge AxiBusClock or negedge xAxiBusReset_n) begin
    if (!xAxiBusReset_n) begin
      state        <= S_IDLE;
      xErrCode     <= 2'd0;
      discard_done <= 1'b0;
      tmo          <= 32'd0;
      xIcapCsib    <= 1'b1;
      xIcapI       <= 32'd0;
      xWordCount   <= 32'd0;
      w0           <= 32'd0;
      w1           <= 32'd0;
      cnt          <= 2'd0;
      tlast_seen   <= 1'b0;
    end else begin
      state        <= state_nxt;
      xErrCode     <= err_nxt;
      discard_done <= disc_nxt;
      if (arm || tmo_clr || state_nxt != state) begin
        tmo <= 32'd0;
      end else if (tmo_inc) begin
        tmo <= tmo + 32'd1;
      end
      xIcapCsib <= ~issue;
      if (issue) xIcapI <= BIT_SWAP ? swap_bits(w0) : w0;
      if (arm) begin
        xWordCount <= 32'd0;
      end else if (issue && xWordCount != 32'hFFFF_FFFF) begin
        xWordCount <= xWordCount + 32'd1;
      end
      // A load only happens when the buffer is empty or draining its last word.
      if (flush || arm) begin
        cnt        <= 2'd0;
        tlast_seen <= 1'b0;
      end else if (hs && state == S_STREAM) begin
        w0         <= xS_AXIS_tdata[31:0];
        w1         <= xS_AXIS_tdata[63:32];
        cnt        <= keep_full ? 2'd2 : 2'd1;
        tlast_seen <= xS_AXIS_tlast;
      end else if (issue) begin
        w0  <= w1;
        cnt <= cnt - 2'd1;
      end
    end
  end

endmodule
